// File: rtl/phase_frame_builder.sv
// Collects time-multiplexed per-hydrophone phase words into rate-limited 6-channel frames.
// Optional build macro PHASE_DIFF_EN: output each channel as a wrapped difference against REF_CH.
module phase_frame_builder #(
  parameter int REF_CH  = 0,
  parameter int HOLDOFF = 16,
  parameter int TIMEOUT = 256,
  parameter int DATA_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [2:0]               in_chan,
  input  logic signed [DATA_W-1:0] in_phase,
  output logic                     out_enable,
  output logic signed [DATA_W-1:0] out_sampl_1,
  output logic signed [DATA_W-1:0] out_sampl_2,
  output logic signed [DATA_W-1:0] out_sampl_3,
  output logic signed [DATA_W-1:0] out_sampl_4,
  output logic signed [DATA_W-1:0] out_sampl_5,
  output logic signed [DATA_W-1:0] out_sampl_6,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               drop_cnt,
  output logic [2:0]               err_flags
);

  localparam int NCH   = 6;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  if (HOLDOFF < 14 || REF_CH < 0 || REF_CH > NCH - 1 || TIMEOUT < 2) begin : g_bad_param
    $error("phase_frame_builder: illegal parameter value");
  end

  typedef enum logic {COLLECT_IDLE, COLLECT_ACTIVE} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (&x) ? x : x + 8'd1;
  endfunction

`ifdef PHASE_DIFF_EN
  // Natural two's-complement wrap is exactly the phase wrap into [-pi,pi).
  function automatic logic signed [DATA_W-1:0] phase_diff(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
    return a - b;
  endfunction
`endif

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] slot_p0 [NCH];
  logic [NCH-1:0]           mask_p0;
  logic [TMR_W-1:0]         timer_p0;
  logic signed [DATA_W-1:0] frame_c [NCH];
  logic signed [DATA_W-1:0] built_c [NCH];
  logic signed [DATA_W-1:0] pend_p1 [NCH];
  logic                     vld_p1;
  logic signed [DATA_W-1:0] out_p2 [NCH];
  logic                     vld_p2;
  logic [HO_W-1:0]          holdoff;
  logic [NCH-1:0]           chan_bit, mask_upd;
  logic                     accept, illegal, dup, complete, tmo, issue, overrun;

  always_comb begin
    state_nxt = state;
    illegal   = in_valid && (in_chan > 3'd5);
    accept    = in_valid && (in_chan <= 3'd5);
    chan_bit  = accept ? (NCH'(1) << in_chan) : '0;
    mask_upd  = mask_p0 | chan_bit;
    dup       = accept && (|(mask_p0 & chan_bit));
    complete  = accept && (mask_upd == 6'h3F);
    tmo       = (state == COLLECT_ACTIVE) && (timer_p0 == TMR_W'(TIMEOUT - 1)) && !complete;
    case (state)
      COLLECT_IDLE:   if (accept && !complete) state_nxt = COLLECT_ACTIVE;
      COLLECT_ACTIVE: if (complete || tmo)     state_nxt = COLLECT_IDLE;
      default:        state_nxt = COLLECT_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= COLLECT_IDLE;
    else       state <= state_nxt;
  end

  // ---- p0: collection buffer, mask and frame timer
  always_ff @(posedge clock) begin
    if (accept) slot_p0[in_chan] <= in_phase;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mask_p0  <= '0;
      timer_p0 <= '0;
    end else begin
      mask_p0  <= (complete || tmo) ? '0 : mask_upd;
      timer_p0 <= (state == COLLECT_IDLE) ? '0 : timer_p0 + TMR_W'(1);
    end
  end

  // The completing sample is merged in so the frame can be copied on its own edge.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      frame_c[k] = (accept && in_chan == 3'(k)) ? in_phase : slot_p0[k];
    end
    for (int k = 0; k < NCH; k++) begin
`ifdef PHASE_DIFF_EN
      built_c[k] = phase_diff(frame_c[k], frame_c[REF_CH]);
`else
      built_c[k] = frame_c[k];
`endif
    end
  end

  // ---- p1: pending frame waiting for holdoff to expire
  assign issue   = vld_p1 && (holdoff == '0);
  assign overrun = complete && vld_p1 && !issue;

  always_ff @(posedge clock) begin
    if (complete) pend_p1 <= built_c;
  end

  always_ff @(posedge clock) begin
    if (reset)         vld_p1 <= 1'b0;
    else if (complete) vld_p1 <= 1'b1;
    else if (issue)    vld_p1 <= 1'b0;
  end

  // ---- p2: issued frame and strobe to the accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) out_p2[k] <= '0;
      vld_p2    <= 1'b0;
      frame_cnt <= '0;
      holdoff   <= '0;
    end else begin
      vld_p2 <= issue;
      if (issue) begin
        out_p2    <= pend_p1;
        frame_cnt <= frame_cnt + 16'd1;
        holdoff   <= HO_W'(HOLDOFF - 1);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HO_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt  <= '0;
      err_flags <= '0;
    end else begin
      if (tmo || overrun) drop_cnt <= sat_inc(drop_cnt);
      err_flags <= err_flags | {overrun, dup, illegal};
    end
  end

  assign out_enable  = vld_p2;
  assign out_sampl_1 = out_p2[0];
  assign out_sampl_2 = out_p2[1];
  assign out_sampl_3 = out_p2[2];
  assign out_sampl_4 = out_p2[3];
  assign out_sampl_5 = out_p2[4];
  assign out_sampl_6 = out_p2[5];

endmodule

// File: tb/tb_phase_frame_builder.sv
// Directed bench for phase_frame_builder; expectations follow the PHASE_DIFF_EN build setting.
module tb_phase_frame_builder;

  localparam int HOLDOFF = 16;
`ifdef PHASE_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [2:0]         in_chan = 3'd0;
  logic signed [15:0] in_phase = 16'sd0;
  logic               out_enable;
  logic signed [15:0] out_sampl_1, out_sampl_2, out_sampl_3, out_sampl_4, out_sampl_5, out_sampl_6;
  logic [15:0]        frame_cnt;
  logic [7:0]         drop_cnt;
  logic [2:0]         err_flags;

  phase_frame_builder #(.REF_CH(0), .HOLDOFF(HOLDOFF), .TIMEOUT(256)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_chan(in_chan), .in_phase(in_phase),
    .out_enable(out_enable),
    .out_sampl_1(out_sampl_1), .out_sampl_2(out_sampl_2), .out_sampl_3(out_sampl_3),
    .out_sampl_4(out_sampl_4), .out_sampl_5(out_sampl_5), .out_sampl_6(out_sampl_6),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_total = 0;
  int hold_bad = 0;
  int en_cyc [64];
  logic signed [15:0] en_s6 [64];
  logic [95:0] prev_out = '0;
  logic signed [15:0] outs [6];

  assign outs[0] = out_sampl_1;
  assign outs[1] = out_sampl_2;
  assign outs[2] = out_sampl_3;
  assign outs[3] = out_sampl_4;
  assign outs[4] = out_sampl_5;
  assign outs[5] = out_sampl_6;

  always @(posedge clock) cyc <= cyc + 1;

  // Records every strobe and counts output changes that happen without one.
  always @(negedge clock) begin
    if (out_enable) begin
      en_cyc[en_total % 64] = cyc;
      en_s6[en_total % 64]  = out_sampl_6;
      en_total = en_total + 1;
    end else if (!reset && {out_sampl_1, out_sampl_2, out_sampl_3, out_sampl_4, out_sampl_5, out_sampl_6} !== prev_out) begin
      hold_bad = hold_bad + 1;
    end
    prev_out = {out_sampl_1, out_sampl_2, out_sampl_3, out_sampl_4, out_sampl_5, out_sampl_6};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [2:0] ch, input int ph);
    in_valid = 1'b1;
    in_chan  = ch;
    in_phase = 16'(ph);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_enable !== 1'b0) begin bad++; $display("FAIL reset_en: got %0d want 0", out_enable); end
    for (int k = 0; k < 6; k++) begin
      total++; if (outs[k] !== 16'sd0) begin bad++; $display("FAIL reset_sampl%0d: got %0d want 0", k + 1, outs[k]); end
    end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err_flags); end
  endtask

  task automatic test_basic();
    logic signed [15:0] e;
    do_reset();
    for (int k = 0; k < 6; k++) send(3'(k), 100 * (k + 1));
    total++; if (out_enable !== 1'b0) begin bad++; $display("FAIL basic_early_en: got %0d want 0", out_enable); end
    tick();
    total++; if (out_enable !== 1'b1) begin bad++; $display("FAIL basic_en: got %0d want 1", out_enable); end
    for (int k = 0; k < 6; k++) begin
      e = DIFF ? 16'(100 * k) : 16'(100 * (k + 1));
      total++; if (outs[k] !== e) begin bad++; $display("FAIL basic_sampl%0d: got %0d want %0d", k + 1, outs[k], e); end
    end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    tick();
    total++; if (out_enable !== 1'b0) begin bad++; $display("FAIL basic_en_pulse: got %0d want 0", out_enable); end
  endtask

  task automatic test_wrap();
    logic signed [15:0] e2, e4;
    do_reset();
    send(3'd0, -32000); send(3'd1, 0); send(3'd2, 0);
    send(3'd3, 32000);  send(3'd4, 0); send(3'd5, 0);
    tick();
    e2 = DIFF ? 16'sd32000 : 16'sd0;
    e4 = DIFF ? -16'sd1536 : 16'sd32000;
    total++; if (out_enable !== 1'b1) begin bad++; $display("FAIL wrap_en: got %0d want 1", out_enable); end
    total++; if (out_sampl_2 !== e2) begin bad++; $display("FAIL wrap_sampl2: got %0d want %0d", out_sampl_2, e2); end
    total++; if (out_sampl_4 !== e4) begin bad++; $display("FAIL wrap_sampl4: got %0d want %0d", out_sampl_4, e4); end
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL wrap_err: got %b want 000", err_flags); end
  endtask

  task automatic test_back_to_back();
    int base, hb;
    logic signed [15:0] e1, e2;
    do_reset();
    base = en_total;
    hb = hold_bad;
    for (int k = 0; k < 6; k++) send(3'(k), 100 + 10 * k);
    for (int k = 0; k < 6; k++) send(3'(k), 200 + 20 * k);
    repeat (20) tick();
    e1 = DIFF ? 16'sd50 : 16'sd150;
    e2 = DIFF ? 16'sd100 : 16'sd300;
    total++; if (en_total - base !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", en_total - base); end
    total++; if (en_cyc[(base + 1) % 64] - en_cyc[base % 64] !== HOLDOFF) begin
      bad++; $display("FAIL b2b_spacing: got %0d want %0d", en_cyc[(base + 1) % 64] - en_cyc[base % 64], HOLDOFF); end
    total++; if (en_s6[base % 64] !== e1) begin bad++; $display("FAIL b2b_frame1: got %0d want %0d", en_s6[base % 64], e1); end
    total++; if (en_s6[(base + 1) % 64] !== e2) begin bad++; $display("FAIL b2b_frame2: got %0d want %0d", en_s6[(base + 1) % 64], e2); end
    total++; if (hold_bad - hb !== 0) begin bad++; $display("FAIL b2b_hold: got %0d changes want 0", hold_bad - hb); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_overrun();
    int base;
    logic signed [15:0] e1, e3;
    do_reset();
    base = en_total;
    for (int f = 1; f <= 3; f++)
      for (int k = 0; k < 6; k++) send(3'(k), f * 100 + f * 10 * k);
    repeat (20) tick();
    e1 = DIFF ? 16'sd50 : 16'sd150;
    e3 = DIFF ? 16'sd150 : 16'sd450;
    total++; if (en_total - base !== 2) begin bad++; $display("FAIL ovr_count: got %0d want 2", en_total - base); end
    total++; if (en_s6[base % 64] !== e1) begin bad++; $display("FAIL ovr_frame1: got %0d want %0d", en_s6[base % 64], e1); end
    total++; if (en_s6[(base + 1) % 64] !== e3) begin bad++; $display("FAIL ovr_frame3: got %0d want %0d", en_s6[(base + 1) % 64], e3); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovr_drop: got %0d want 1", drop_cnt); end
    total++; if (err_flags !== 3'b100) begin bad++; $display("FAIL ovr_err: got %b want 100", err_flags); end
  endtask

  task automatic test_timeout();
    int base;
    logic signed [15:0] e;
    do_reset();
    base = en_total;
    for (int k = 0; k < 5; k++) send(3'(k), 50 * (k + 1));
    repeat (270) tick();
    total++; if (en_total - base !== 0) begin bad++; $display("FAIL tmo_no_en: got %0d want 0", en_total - base); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL tmo_drop: got %0d want 1", drop_cnt); end
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL tmo_err: got %b want 000", err_flags); end
    for (int k = 0; k < 6; k++) send(3'(k), 7 + k);
    tick();
    e = DIFF ? 16'sd5 : 16'sd12;
    total++; if (out_enable !== 1'b1) begin bad++; $display("FAIL tmo_next_en: got %0d want 1", out_enable); end
    total++; if (out_sampl_6 !== e) begin bad++; $display("FAIL tmo_next_sampl6: got %0d want %0d", out_sampl_6, e); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL tmo_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_errors_reset();
    do_reset();
    send(3'd7, 999);
    total++; if (err_flags !== 3'b001) begin bad++; $display("FAIL err_illegal: got %b want 001", err_flags); end
    send(3'd2, 10);
    send(3'd2, 20);
    total++; if (err_flags !== 3'b011) begin bad++; $display("FAIL err_dup: got %b want 011", err_flags); end
    send(3'd0, 5);
    do_reset();
    total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL err_after_reset: got %b want 000", err_flags); end
    total++; if (out_sampl_3 !== 16'sd0) begin bad++; $display("FAIL err_sampl3_reset: got %0d want 0", out_sampl_3); end
    send(3'd0, 0); send(3'd1, 7); send(3'd2, 33);
    send(3'd3, 0); send(3'd4, 0); send(3'd5, 0);
    tick();
    total++; if (out_enable !== 1'b1) begin bad++; $display("FAIL err_new_en: got %0d want 1", out_enable); end
    total++; if (out_sampl_3 !== 16'sd33) begin bad++; $display("FAIL err_new_sampl3: got %0d want 33", out_sampl_3); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL err_new_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL err_new_drop: got %0d want 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_errors_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
